// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: operation encoding and next-state rule.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    function automatic logic jk_next(input logic q, input logic [1:0] op);
        logic   r;
        jk_op_t o;
        o = jk_op_t'(op);
        r = q;
        unique case (o)
            JK_HOLD:   r = q;
            JK_RESET:  r = 1'b0;
            JK_SET:    r = 1'b1;
            JK_TOGGLE: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally.
module jk_cmd_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop never frees a slot for a push in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_cmd_seq.sv
// JK command sequencer: buffers {op,len} commands, plays them out on j/k and
// tracks the expected flip-flop state, flagging disagreement with q_in.
module jk_cmd_seq
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    input  logic             q_in,
    input  logic             check_en,
    output logic             busy,
    output logic             done,
    output logic             q_model,
    output logic             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = CNT_W + 2;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;

    logic [FW-1:0]    head;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             last_cycle;

    jk_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({cmd_op, cmd_len}),
        .pop   (fifo_pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full)
    );

    assign head_op    = head[FW-1 -: 2];
    assign head_len   = head[CNT_W-1:0];
    assign fifo_empty = (fifo_count == '0);
    assign cmd_ready  = !fifo_full;
    assign fifo_push  = cmd_valid && cmd_ready;
    assign last_cycle = (state == StRun) && (remaining == CNT_W'(1));
    assign busy       = (state == StRun) || !fifo_empty;

    // A zero-length head is left for IDLE so its done pulse stays separate.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (state == StIdle) begin
                fifo_pop = 1'b1;
            end else if (last_cycle && (head_len != '0)) begin
                fifo_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            j         <= 1'b0;
            k         <= 1'b0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!fifo_empty) begin
                        if (head_len != '0) begin
                            {j, k}    <= head_op;
                            remaining <= head_len;
                            state     <= StRun;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (last_cycle) begin
                        done <= 1'b1;
                        if (fifo_pop) begin
                            {j, k}    <= head_op;
                            remaining <= head_len;
                        end else begin
                            {j, k}    <= 2'b00;
                            remaining <= '0;
                            state     <= StIdle;
                        end
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= StIdle;
                    {j, k} <= 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_model <= 1'b0;
            err     <= 1'b0;
        end else begin
            q_model <= jk_next(q_model, {j, k});
            if (check_en && (q_in != q_model)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
